// File: rtl/whiz_line_renderer_if.sv
// whiz_line_renderer_if: VRAM read port and pixel stream between the renderer and its neighbours
//   vram_req/vram_addr/vram_ack/vram_rdata : read request, held until ack
//   pix_valid/pix_ready/pix_data/pix_x     : one pixel per accepted beat
//   master = renderer side, slave = VRAM arbiter / line buffer side
interface whiz_line_renderer_if #(
    parameter int ADDR_W = 13
);
    logic              vram_req;
    logic [ADDR_W-1:0] vram_addr;
    logic              vram_ack;
    logic [7:0]        vram_rdata;
    logic              pix_valid;
    logic              pix_ready;
    logic [1:0]        pix_data;
    logic [7:0]        pix_x;

    modport master (
        output vram_req, vram_addr, pix_valid, pix_data, pix_x,
        input  vram_ack, vram_rdata, pix_ready
    );

    modport slave (
        input  vram_req, vram_addr, pix_valid, pix_data, pix_x,
        output vram_ack, vram_rdata, pix_ready
    );
endinterface

// File: rtl/whiz_line_renderer.sv
// whiz_line_renderer: scrolled 2bpp tile scanline renderer fetching map/tile bytes over a req/ack VRAM port
//   clk, reset (async, active low)
//   bus       : whiz_line_renderer_if.master (VRAM req/ack port and pixel valid/ready stream)
//   drawline  : start pulse; line_num, scroll_x, scroll_y (and bgp) are sampled with it
//   busy      : line in progress; line_done: one-cycle end-of-line pulse
//   Optional palette mapping through bgp when WHIZ_LINE_PALETTE_EN is defined.
module whiz_line_renderer #(
    parameter int                LINE_WIDTH = 160,
    parameter int                LINES      = 144,
    parameter int                MAP_TILES  = 32,
    parameter int                ADDR_W     = 13,
    parameter logic [ADDR_W-1:0] MAP_BASE   = 13'h1800,
    parameter logic [ADDR_W-1:0] TILE_BASE  = 13'h0000
) (
    input  logic                        clk,
    input  logic                        reset,
    whiz_line_renderer_if.master        bus,
    input  logic                        drawline,
    input  logic [7:0]                  line_num,
    input  logic [7:0]                  scroll_x,
    input  logic [7:0]                  scroll_y,
`ifdef WHIZ_LINE_PALETTE_EN
    input  logic [7:0]                  bgp,
`endif
    output logic                        busy,
    output logic                        line_done
);
    localparam int PW = $clog2(MAP_TILES * 8);

    typedef enum logic [2:0] {IDLE, MAP, LO, HI, EMIT, DONE} state_t;

    state_t            state;
    logic [7:0]        ln, sx, sy, idx, lo, hi, px;
    logic              vram_req, pix_valid;
    logic [ADDR_W-1:0] vram_addr;
    logic [1:0]        pix_data;
    logic [PW-1:0]     y, xm;
    logic [2:0]        nfine;
    logic [ADDR_W-1:0] map_addr, tile_addr;
    logic              last;
`ifdef WHIZ_LINE_PALETTE_EN
    logic [7:0]        pal;
`endif

    assign bus.vram_req  = vram_req;
    assign bus.vram_addr = vram_addr;
    assign bus.pix_valid = pix_valid;
    assign bus.pix_data  = pix_data;
    assign bus.pix_x     = px;

    // Pixel-space coordinates wrap at the map size, so truncating to PW bits is the modulo.
    assign y         = PW'(int'(ln) + int'(sy));
    assign xm        = PW'(int'(px) + int'(sx));
    assign map_addr  = ADDR_W'(int'(MAP_BASE) + int'(y >> 3) * MAP_TILES + int'(xm >> 3));
    assign tile_addr = ADDR_W'(int'(TILE_BASE) + int'(idx) * 16 + int'(y[2:0]) * 2);
    assign last      = int'(px) + 1 >= LINE_WIDTH;
    assign nfine     = xm[2:0] + 3'd1;

    // Bit 7 of each plane byte is the leftmost pixel, hence the ~f index.
    function automatic logic [1:0] shade(input logic [7:0] h, input logic [7:0] l, input logic [2:0] f);
        logic [1:0] c;
        c = {h[~f], l[~f]};
`ifdef WHIZ_LINE_PALETTE_EN
        return pal[{c, 1'b0} +: 2];
`else
        return c;
`endif
    endfunction

    // A request is raised on the first cycle in MAP/LO/HI (req still low) and the state
    // advances on ack, so req is never re-raised in the ack cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ln        <= '0;
            sx        <= '0;
            sy        <= '0;
            idx       <= '0;
            lo        <= '0;
            hi        <= '0;
            px        <= '0;
            vram_req  <= 1'b0;
            vram_addr <= '0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
            busy      <= 1'b0;
            line_done <= 1'b0;
`ifdef WHIZ_LINE_PALETTE_EN
            pal       <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (drawline) begin
                    ln <= line_num;
                    sx <= scroll_x;
                    sy <= scroll_y;
                    px <= '0;
`ifdef WHIZ_LINE_PALETTE_EN
                    pal <= bgp;
`endif
                    if (int'(line_num) >= LINES) begin
                        line_done <= 1'b1;
                        state     <= DONE;
                    end else begin
                        busy  <= 1'b1;
                        state <= MAP;
                    end
                end
                MAP: if (!vram_req) begin
                    vram_req  <= 1'b1;
                    vram_addr <= map_addr;
                end else if (bus.vram_ack) begin
                    vram_req <= 1'b0;
                    idx      <= bus.vram_rdata;
                    state    <= LO;
                end
                LO: if (!vram_req) begin
                    vram_req  <= 1'b1;
                    vram_addr <= tile_addr;
                end else if (bus.vram_ack) begin
                    vram_req <= 1'b0;
                    lo       <= bus.vram_rdata;
                    state    <= HI;
                end
                HI: if (!vram_req) begin
                    vram_req  <= 1'b1;
                    vram_addr <= tile_addr + 1'b1;
                end else if (bus.vram_ack) begin
                    vram_req  <= 1'b0;
                    hi        <= bus.vram_rdata;
                    pix_valid <= 1'b1;
                    pix_data  <= shade(bus.vram_rdata, lo, xm[2:0]);
                    state     <= EMIT;
                end
                EMIT: if (bus.pix_ready) begin
                    px <= px + 8'd1;
                    if (last) begin
                        pix_valid <= 1'b0;
                        busy      <= 1'b0;
                        line_done <= 1'b1;
                        state     <= DONE;
                    end else if (nfine == 3'd0) begin
                        pix_valid <= 1'b0;
                        state     <= MAP;
                    end else begin
                        pix_data <= shade(hi, lo, nfine);
                    end
                end
                DONE: begin
                    line_done <= 1'b0;
                    px        <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_whiz_line_renderer.sv
// tb_whiz_line_renderer: randomized and directed line renders checked against a per-pixel reference model
module tb_whiz_line_renderer;
    localparam int LW   = 160;
    localparam int NL   = 144;
    localparam int MT   = 32;
    localparam int AW   = 13;
    localparam int MAPB = 'h1800;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       drawline = 1'b0;
    logic [7:0] line_num = '0;
    logic [7:0] scroll_x = '0;
    logic [7:0] scroll_y = '0;
    logic       busy, line_done;
`ifdef WHIZ_LINE_PALETTE_EN
    logic [7:0] bgp = 8'hE4;
`endif

    whiz_line_renderer_if #(.ADDR_W(AW)) bus ();

    whiz_line_renderer #(
        .LINE_WIDTH(LW), .LINES(NL), .MAP_TILES(MT), .ADDR_W(AW),
        .MAP_BASE(13'h1800), .TILE_BASE(13'h0000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .drawline(drawline),
        .line_num(line_num),
        .scroll_x(scroll_x),
        .scroll_y(scroll_y),
`ifdef WHIZ_LINE_PALETTE_EN
        .bgp(bgp),
`endif
        .busy(busy),
        .line_done(line_done)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:8191];
    int n_cmp = 0;
    int n_bad = 0;
    int min_delay = 0;
    int max_delay = 0;
    int ready_pct = 100;
    int stall_at = -1;
    int stable_err = 0;
    int req_err = 0;
    int done_cnt = 0;
    int got_addr[$];
    int got_x[$];
    int got_pix[$];

    task automatic check(input string tag, input int obs, input int want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, want);
        end
    endtask

    function automatic int colour(input int c);
`ifdef WHIZ_LINE_PALETTE_EN
        return (int'(bgp) >> (2 * c)) & 3;
`else
        return c;
`endif
    endfunction

    // VRAM model: random ack latency, address must hold while req is high,
    // req must be low in the cycle after ack.
    initial begin
        int cnt, dly;
        logic [AW-1:0] held;
        cnt = 0; dly = 0; held = '0;
        bus.vram_ack = 1'b0;
        bus.vram_rdata = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                bus.vram_ack = 1'b0;
                cnt = 0;
            end else if (bus.vram_ack) begin
                bus.vram_ack = 1'b0;
                if (bus.vram_req) req_err++;
            end else if (bus.vram_req) begin
                if (cnt == 0) begin
                    held = bus.vram_addr;
                    dly = $urandom_range(min_delay, max_delay);
                end else if (bus.vram_addr !== held) stable_err++;
                if (cnt >= dly) begin
                    bus.vram_ack = 1'b1;
                    bus.vram_rdata = mem[bus.vram_addr];
                    got_addr.push_back(int'(bus.vram_addr));
                    cnt = 0;
                end else cnt++;
            end
        end
    end

    // Pixel sink: random/forced backpressure, records accepted beats, checks stall stability.
    initial begin
        logic pend;
        logic [7:0] hx;
        logic [1:0] hd;
        int st;
        pend = 1'b0; hx = '0; hd = '0; st = 0;
        bus.pix_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (line_done) done_cnt++;
            if (!reset) pend = 1'b0;
            else if (pend && (!bus.pix_valid || bus.pix_x !== hx || bus.pix_data !== hd)) stable_err++;
            bus.pix_ready = $urandom_range(0, 99) < ready_pct;
            if (int'(bus.pix_x) != stall_at) st = 0;
            else if (bus.pix_valid && st < 5) begin
                bus.pix_ready = 1'b0;
                st++;
            end
            if (reset && bus.pix_valid && bus.pix_ready) begin
                got_x.push_back(int'(bus.pix_x));
                got_pix.push_back(int'(bus.pix_data));
                pend = 1'b0;
            end else begin
                pend = bus.pix_valid;
                hx = bus.pix_x;
                hd = bus.pix_data;
            end
        end
    end

    task automatic run_line(input int ln, input int sx, input int sy, input bit extra,
                            output int pb, output int ab);
        int db, eb, cyc, y, xm, idx, ta, f, c;
        int ea[$];
        int ep[$];
        y = (ln + sy) % (MT * 8);
        if (ln < NL) for (int x = 0; x < LW; x++) begin
            xm = (x + sx) % (MT * 8);
            idx = int'(mem[MAPB + (y / 8) * MT + xm / 8]);
            ta = idx * 16 + (y % 8) * 2;
            if (x == 0 || xm % 8 == 0) begin
                ea.push_back(MAPB + (y / 8) * MT + xm / 8);
                ea.push_back(ta);
                ea.push_back(ta + 1);
            end
            f = 7 - xm % 8;
            c = 2 * ((int'(mem[ta + 1]) >> f) & 1) + ((int'(mem[ta]) >> f) & 1);
            ep.push_back(colour(c));
        end
        pb = got_pix.size();
        ab = got_addr.size();
        db = done_cnt;
        eb = stable_err + req_err;
        line_num = 8'(ln);
        scroll_x = 8'(sx);
        scroll_y = 8'(sy);
        drawline = 1'b1;
        @(negedge clk);
        drawline = 1'b0;
        check("busy_start", int'(busy), int'(ln < NL));
        cyc = 0;
        while (!line_done && cyc < 5000) begin
            drawline = extra && cyc == 20;
            @(negedge clk);
            cyc++;
        end
        check("done_seen", int'(cyc < 5000), 1);
        check("busy_at_done", int'(busy), 0);
        drawline = extra;
        @(negedge clk);
        drawline = 1'b0;
        repeat (8) @(negedge clk);
        check("done_count", done_cnt - db, 1);
        check("pix_count", got_pix.size() - pb, ep.size());
        check("read_count", got_addr.size() - ab, ea.size());
        if (got_pix.size() - pb == ep.size())
            for (int i = 0; i < ep.size(); i++) begin
                check($sformatf("pix_data[%0d]", i), got_pix[pb + i], ep[i]);
                check($sformatf("pix_x[%0d]", i), got_x[pb + i], i);
            end
        if (got_addr.size() - ab == ea.size())
            for (int i = 0; i < ea.size(); i++)
                check($sformatf("vram_addr[%0d]", i), got_addr[ab + i], ea[i]);
        check("handshake_rules", stable_err + req_err - eb, 0);
        check("busy_idle", int'(busy), 0);
    endtask

    initial begin
        int pb, ab, nmap, cyc;
        int pat[8];
        int fine_pat[5];
        pat = '{3, 3, 1, 1, 2, 2, 0, 0};
        fine_pat = '{1, 2, 2, 0, 0};
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        mem[0] = 8'hF0;
        mem[1] = 8'hCC;

        repeat (3) @(negedge clk);
        check("rst_vram_req", int'(bus.vram_req), 0);
        check("rst_vram_addr", int'(bus.vram_addr), 0);
        check("rst_pix_valid", int'(bus.pix_valid), 0);
        check("rst_pix_data", int'(bus.pix_data), 0);
        check("rst_pix_x", int'(bus.pix_x), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_line_done", int'(line_done), 0);
        reset = 1'b1;
        @(negedge clk);

        run_line(0, 0, 0, 1'b1, pb, ab);
        check("basic_reads", got_addr.size() - ab, 60);
        for (int i = 0; i < 16; i++) check($sformatf("basic_pat[%0d]", i), got_pix[pb + i], colour(pat[i % 8]));

        run_line(0, 3, 0, 1'b0, pb, ab);
        for (int i = 0; i < 5; i++) check($sformatf("fine_pat[%0d]", i), got_pix[pb + i], colour(fine_pat[i]));
        check("fine_pat[5]", got_pix[pb + 5], colour(3));
        nmap = 0;
        for (int i = ab; i < got_addr.size(); i++) if (got_addr[i] >= MAPB) nmap++;
        check("fine_map_reads", nmap, 21);

        stall_at = 10; min_delay = 4; max_delay = 4;
        run_line(0, 0, 0, 1'b0, pb, ab);
        stall_at = -1; min_delay = 0; max_delay = 0;

`ifdef WHIZ_LINE_PALETTE_EN
        bgp = 8'h1B;
        run_line(0, 0, 0, 1'b0, pb, ab);
        for (int i = 0; i < 8; i++) check($sformatf("pal_pat[%0d]", i), got_pix[pb + i], (i / 2) == 0 ? 0 : (i / 2) == 1 ? 2 : (i / 2) == 2 ? 1 : 3);
        bgp = 8'hE4;
`endif

        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);

        run_line(10, 252, 250, 1'b0, pb, ab);
        check("wrap_map0", got_addr[ab], MAPB + 31);
        check("wrap_row", got_addr[ab + 1], int'(mem[MAPB + 31]) * 16 + 8);
        check("wrap_map1", got_addr[ab + 3], MAPB);

        run_line(144, 0, 0, 1'b0, pb, ab);
        check("off_screen_reads", got_addr.size() - ab, 0);

        line_num = 8'd5;
        scroll_x = 8'd17;
        scroll_y = 8'd9;
        drawline = 1'b1;
        @(negedge clk);
        drawline = 1'b0;
        cyc = 0;
        while (!(bus.pix_valid && bus.pix_x >= 8'd20) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check("reached_emit", int'(cyc < 3000), 1);
        #2 reset = 1'b0;
        #1;
        check("async_pix_valid", int'(bus.pix_valid), 0);
        check("async_vram_req", int'(bus.vram_req), 0);
        check("async_busy", int'(busy), 0);
        check("async_line_done", int'(line_done), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_line(5, 17, 9, 1'b0, pb, ab);

        for (int n = 0; n < 6; n++) begin
            max_delay = $urandom_range(0, 3);
            ready_pct = $urandom_range(50, 100);
            run_line($urandom_range(0, NL - 1), $urandom_range(0, 255), $urandom_range(0, 255),
                     1'($urandom_range(0, 1)), pb, ab);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/whiz_line_renderer.md
Name: whiz_line_renderer

Overview:
- Parametrised scanline renderer, successor to the whizgraphics single-line tile renderer.
- On each drawline pulse, fetches background map entries and 2bpp tile rows from VRAM through a req/ack port.
- Applies X/Y scroll with map wrap-around and streams one line of pixels over a valid/ready interface.
- Sits between the VRAM arbiter and the LCD line buffer; line_done replaces the old renderComplete.

Parameters:
- LINE_WIDTH, 160, visible pixels per line (multiple of 8 not required).
- LINES, 144, visible lines; valid line_num range is 0..LINES-1.
- MAP_TILES, 32, map width and height in tiles; power of 2.
- ADDR_W, 13, VRAM byte address width.
- MAP_BASE, 13'h1800, byte address of map entry (0,0).
- TILE_BASE, 13'h0000, byte address of tile 0; 16 bytes per tile.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- drawline  in  1  one-cycle start pulse
- line_num  in  8  line to render; sampled on drawline
- scroll_x  in  8  sampled on drawline
- scroll_y  in  8  sampled on drawline
- vram_req  out  1  read request; held until ack
- vram_addr  out  ADDR_W  read address; stable while vram_req is high
- vram_ack  in  1  read done; vram_rdata valid in this cycle
- vram_rdata  in  8  read data
- pix_valid  out  1  pixel available
- pix_ready  in  1  sink accepts pixel
- pix_data  out  2  pixel colour
- pix_x  out  8  screen x of the current pixel, 0..LINE_WIDTH-1
- busy  out  1  line in progress
- line_done  out  1  one-cycle pulse at end of line

Behaviour:
- Reset (reset low, asynchronous): FSM goes to IDLE; all outputs are 0.
- FSM states: IDLE, MAP, LO, HI, EMIT, DONE.
- IDLE: on drawline, latch inputs; next cycle go to MAP and assert busy.
- If line_num >= LINES: go directly to DONE; no VRAM reads, no pixels.
- Coordinates:
  - y = (line_num + scroll_y) mod (MAP_TILES*8).
  - xm = (pix_x + scroll_x) mod (MAP_TILES*8).
- MAP: vram_addr = MAP_BASE + (y>>3)*MAP_TILES + (xm>>3). On ack, latch idx as an 8-bit unsigned value.
- LO: vram_addr = TILE_BASE + idx*16 + (y&7)*2.
- HI: same address +1.
- Request rules: vram_req rises in the cycle after entering the state. It drops in the cycle after ack. It must not re-assert in the ack cycle.
- EMIT: fine = xm&7; pix_data = {hi[7-fine], lo[7-fine]}.
  - pix_valid stays high with pix_data and pix_x stable until pix_ready is high.
  - On each accept, pix_x increments.
  - If pix_x reaches LINE_WIDTH, go to DONE.
  - Else if the new xm&7 == 0, go to MAP.
  - Else stay in EMIT.
- The first tile is partial (starts at scroll_x&7). The last tile is truncated at LINE_WIDTH.
- DONE: line_done = 1 for one cycle, busy drops in the same cycle, then return to IDLE.
- drawline while busy is ignored (no restart, no queueing).
- drawline in the same cycle as DONE is ignored.
- Column wrap: map column MAP_TILES-1 is followed by column 0; row computation is mod MAP_TILES.
- Address arithmetic is truncated to ADDR_W bits.

Optional Feature:
- Macro: WHIZ_LINE_PALETTE_EN.
- With the macro defined:
  - Adds input bgp[7:0].
  - The raw colour c = {hi, lo} is mapped to pix_data = bgp[2c+1 -: 2].
  - bgp is sampled on drawline and held for the whole line.
- Without the macro: no bgp port; pix_data is the raw colour index.

Test Plan:
- Reset: assert reset low mid-EMIT -> same cycle, pix_valid, vram_req, busy and line_done are all 0. Release reset, then drawline -> full line renders normally.
- Basic line, scroll 0/0, line 0: map all 0x00; tile 0 row 0 lo=0xF0, hi=0xCC -> 160 pixels repeating 3,3,1,1,2,2,0,0. Expect 60 VRAM reads (20 tiles x 3) and one line_done after pixel 159.
- Fine scroll, scroll_x=3: same data -> first pixels 1,2,2,0,0 then 3,3,1,1,... Expect 160 pixels total, 21 map reads, last tile truncated after 3 pixels.
- Backpressure: drop pix_ready for 5 cycles at pix_x=10; also delay vram_ack 4 cycles -> pix_data/pix_x and vram_addr held stable; sink receives exactly 160 pixels in order.
- Wrap, scroll_y=250, line 10, scroll_x=252: expect y=4 (tile row 4, map row 0); first map address MAP_BASE+31, then MAP_BASE+0. line_num=144 -> line_done with no reads.
- Palette (WHIZ_LINE_PALETTE_EN): bgp=0xE4 -> output identical to raw colours; bgp=0x1B -> pattern 0,0,2,2,1,1,3,3. drawline while busy -> ignored; exactly one line_done.
